// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin arbiter that time-shares one combinational ALU between two
// requesters. Each requester uses a valid/ready request channel and a
// valid/ready response channel. Only one operation is in flight at a time.
// The response result and flags share one bus. The rspN_valid lines say
// which requester the bus currently belongs to.

module alu_share_arbiter #(
    parameter int WIDTH   = 8,   // operand/result width, must match the ALU
    parameter int ALU_LAT = 1    // cycles operands sit on the ALU, 1..15
) (
    input  logic             clk,
    input  logic             rst_n,

    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    // responses (shared data bus, per-requester valid/ready)
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [4:0]       rsp_flags,

    // ALU side
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_oe,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_parity,
    input  logic             alu_overflow,
    input  logic             alu_greater,
    input  logic             alu_is_eq,
    input  logic             alu_less,

    // status
    output logic             busy,
    output logic [15:0]      done_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // lat_cnt is loaded with ALU_LAT-1, so ISSUE lasts exactly ALU_LAT cycles
    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

    state_t      state;
    logic [3:0]  lat_cnt;
    logic [15:0] done_cnt_q;

    // last_grant doubles as the owner of the in-flight operation: it is
    // written with the granted requester at accept time and only changes
    // again at the next accept, which cannot happen before the response
    // has been taken.
    logic        last_grant;

    logic        grant_valid;
    logic        grant_id;
    logic        owner_rsp_ready;
    logic        rsp_handshake;

    // Round-robin grant decision, only meaningful while IDLE
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so that no path through the block leaves it unassigned (a latch).
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Request handshake completes in the same cycle the grant is decided
    assign req0_ready = grant_valid && (grant_id == 1'b0);
    assign req1_ready = grant_valid && (grant_id == 1'b1);

    // Response handshake with whichever requester owns the result
    assign owner_rsp_ready = last_grant ? rsp1_ready : rsp0_ready;
    assign rsp_handshake   = (state == RESP) && owner_rsp_ready;

    assign busy     = (state != IDLE);
    assign done_cnt = done_cnt_q;

    // Control FSM with registered ALU-side and response-side outputs
    always_ff @(posedge clk) begin
        // NOTE: all state in clocked blocks uses non-blocking assignments, so
        // every register samples the pre-edge values of the others.
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;   // requester 0 wins the first tie
            lat_cnt    <= 4'd0;
            alu_oe     <= 1'b0;
            alu_op     <= 2'b00;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_y      <= '0;
            rsp_flags  <= 5'b0;
            done_cnt_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        // The ALU output registers double as the latched
                        // operation, so they are held for the whole ISSUE.
                        last_grant <= grant_id;
                        alu_oe     <= 1'b1;
                        alu_op     <= grant_id ? req1_op : req0_op;
                        alu_a      <= grant_id ? req1_a  : req0_a;
                        alu_b      <= grant_id ? req1_b  : req0_b;
                        lat_cnt    <= LAT_INIT;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        rsp_y      <= alu_y;
                        rsp_flags  <= {alu_parity, alu_overflow, alu_greater,
                                       alu_is_eq, alu_less};
                        rsp0_valid <= ~last_grant;
                        rsp1_valid <= last_grant;
                        // ALU inputs return to zero outside ISSUE
                        alu_oe     <= 1'b0;
                        alu_op     <= 2'b00;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        state      <= RESP;
                    end
                end

                RESP: begin
                    // No timeout: the result waits for the owner indefinitely
                    if (rsp_handshake) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        done_cnt_q <= done_cnt_q + 16'd1;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter.
// Two instances share the requester inputs: u1 (ALU_LAT=1) and u3
// (ALU_LAT=3). Only one of them is out of reset at any time. Each instance
// has its own behavioural ALU.

module tb_alu_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n1, rst_n3;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_ready, rsp1_ready;

    // u1 signals
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0] rsp_y;
    logic [4:0] rsp_flags;
    logic [1:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic       alu_oe, alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less;
    logic       busy;
    logic [15:0] done_cnt;

    // u3 signals
    logic       req0_ready_3, req1_ready_3, rsp0_valid_3, rsp1_valid_3;
    logic [7:0] rsp_y_3;
    logic [4:0] rsp_flags_3;
    logic [1:0] alu_op_3;
    logic [7:0] alu_a_3, alu_b_3, alu_y_3;
    logic       alu_oe_3, alu_parity_3, alu_overflow_3, alu_greater_3, alu_is_eq_3, alu_less_3;
    logic       busy_3;
    logic [15:0] done_cnt_3;

    // ALU model: 00 add, 01 sub, 10 and, 11 xor; unsigned compare; drives
    // zero while not enabled. Returns {parity, ov, gt, eq, lt, y}.
    function automatic logic [12:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic oe);
        logic [7:0] y;
        logic       ov;
        y  = 8'h00;
        ov = 1'b0;
        case (op)
            2'b00: begin y = a + b; ov = (a[7] == b[7]) && (y[7] != a[7]); end
            2'b01: begin y = a - b; ov = (a[7] != b[7]) && (y[7] != a[7]); end
            2'b10: y = a & b;
            default: y = a ^ b;
        endcase
        if (!oe) return 13'h0;
        return {^y, ov, a > b, a == b, a < b, y};
    endfunction

    assign {alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less, alu_y} =
        alu_model(alu_op, alu_a, alu_b, alu_oe);
    assign {alu_parity_3, alu_overflow_3, alu_greater_3, alu_is_eq_3, alu_less_3, alu_y_3} =
        alu_model(alu_op_3, alu_a_3, alu_b_3, alu_oe_3);

    alu_share_arbiter #(.WIDTH(8), .ALU_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n1),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_oe(alu_oe),
        .alu_y(alu_y), .alu_parity(alu_parity), .alu_overflow(alu_overflow),
        .alu_greater(alu_greater), .alu_is_eq(alu_is_eq), .alu_less(alu_less),
        .busy(busy), .done_cnt(done_cnt)
    );

    alu_share_arbiter #(.WIDTH(8), .ALU_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n3),
        .req0_valid(req0_valid), .req0_ready(req0_ready_3), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready_3), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid_3), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid_3), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y_3), .rsp_flags(rsp_flags_3),
        .alu_op(alu_op_3), .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_oe(alu_oe_3),
        .alu_y(alu_y_3), .alu_parity(alu_parity_3), .alu_overflow(alu_overflow_3),
        .alu_greater(alu_greater_3), .alu_is_eq(alu_is_eq_3), .alu_less(alu_less_3),
        .busy(busy_3), .done_cnt(done_cnt_3)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; return at the falling edge (sample/drive point)
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transaction on u1 from requester id, checking the result
    task automatic run_vec(input string name, input logic id, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_y, input logic [4:0] exp_flags);
        int n;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            tick();
            n++;
        end
        check({name, "_ready"}, id ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!(id ? rsp1_valid : rsp0_valid) && n < 20) begin
            tick();
            n++;
        end
        check({name, "_rsp_valid"}, id ? rsp1_valid : rsp0_valid, 1);
        check({name, "_other_valid"}, id ? rsp0_valid : rsp1_valid, 0);
        check({name, "_y"}, rsp_y, exp_y);
        check({name, "_flags"}, rsp_flags, exp_flags);
        if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic       id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_y;
        logic [4:0] exp_flags;   // {parity, overflow, greater, is_eq, less}
    } vec_t;

    vec_t vecs[7];
    int   order[8];
    int   grants;

    initial begin
        vecs[0] = '{"add_05_03", 1'b0, 2'b00, 8'h05, 8'h03, 8'h08, 5'b10100};
        vecs[1] = '{"sub_10_20", 1'b1, 2'b01, 8'h10, 8'h20, 8'hF0, 5'b00001};
        vecs[2] = '{"add_ovf",   1'b0, 2'b00, 8'h7F, 8'h01, 8'h80, 5'b11100};
        vecs[3] = '{"and_f0_3c", 1'b1, 2'b10, 8'hF0, 8'h3C, 8'h30, 5'b00100};
        vecs[4] = '{"xor_eq",    1'b0, 2'b11, 8'hAA, 8'hAA, 8'h00, 5'b00010};
        vecs[5] = '{"sub_ovf",   1'b1, 2'b01, 8'h80, 8'h01, 8'h7F, 5'b11100};
        vecs[6] = '{"add_wrap",  1'b0, 2'b00, 8'hFF, 8'h01, 8'h00, 5'b00100};

        rst_n1 = 1'b0; rst_n3 = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'b00; req1_op = 2'b00;
        req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // ---- reset state
        check("rst_busy", busy, 0);
        check("rst_alu_oe", alu_oe, 0);
        check("rst_alu_ab", {alu_op, alu_a, alu_b}, 0);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_busy_3", busy_3, 0);
        rst_n1 = 1'b1;
        tick();

        // ---- first transaction, cycle-accurate
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h05; req0_b = 8'h03;
        #1;
        check("t1_req0_ready", req0_ready, 1);
        check("t1_req1_ready", req1_ready, 0);
        check("t1_oe_idle", alu_oe, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t1_ready_drop", req0_ready, 0);
        check("t1_oe_issue", alu_oe, 1);
        check("t1_alu_ops", {alu_op, alu_a, alu_b}, {2'b00, 8'h05, 8'h03});
        check("t1_busy", busy, 1);
        check("t1_no_rsp_yet", rsp0_valid, 0);
        tick();
        check("t1_oe_off", alu_oe, 0);
        check("t1_rsp0_valid", rsp0_valid, 1);
        check("t1_rsp1_valid", rsp1_valid, 0);
        check("t1_rsp_y", rsp_y, 8'h08);
        check("t1_rsp_flags", rsp_flags, 5'b10100);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check("t1_valid_drop", rsp0_valid, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_idle", busy, 0);

        // ---- fairness: both valid continuously for four transactions
        rst_n1 = 1'b0;
        tick();
        rst_n1 = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h01; req0_b = 8'h02;  // y=03
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 8'h0F; req1_b = 8'h03;  // y=0C
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        grants = 0;
        #1;
        for (int i = 0; i < 12; i++) begin
            check("fair_one_ready", req0_ready & req1_ready, 0);
            check("fair_one_rsp", rsp0_valid & rsp1_valid, 0);
            if (req0_ready && grants < 8) begin order[grants] = 0; grants++; end
            if (req1_ready && grants < 8) begin order[grants] = 1; grants++; end
            if (rsp0_valid) check("fair_rsp0_y", rsp_y, 8'h03);
            if (rsp1_valid) check("fair_rsp1_y", rsp_y, 8'h0C);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check("fair_grants", grants, 4);
        for (int k = 0; k < 4; k++) check("fair_order", order[k], k % 2);
        check("fair_done_cnt", done_cnt, 4);

        // ---- table of single transactions
        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v].name, vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b,
                    vecs[v].exp_y, vecs[v].exp_flags);
        end
        check("tbl_done_cnt", done_cnt, 11);

        // ---- back-pressure on rsp0 while req1 waits
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h7F; req0_b = 8'h01;
        #1;
        check("bp_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'hF0; req1_b = 8'h3C;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp0_valid", rsp0_valid, 1);
            check("bp_rsp_y", rsp_y, 8'h80);
            check("bp_rsp_flags", rsp_flags, 5'b11100);
            check("bp_req1_ready", req1_ready, 0);
            tick();
        end
        rsp0_ready = 1'b1;
        #1;
        check("bp_no_same_cycle", req1_ready, 0);
        tick();
        rsp0_ready = 1'b0;
        #1;
        check("bp_rsp0_drop", rsp0_valid, 0);
        check("bp_req1_accept", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("bp_rsp1_valid", rsp1_valid, 1);
        check("bp_rsp1_y", rsp_y, 8'h30);
        check("bp_rsp1_flags", rsp_flags, 5'b00100);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        check("bp_done_cnt", done_cnt, 13);

        // ---- reset while in ISSUE abandons the operation
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h11; req0_b = 8'h22;
        tick();
        req0_valid = 1'b0;
        check("ra_in_issue", alu_oe, 1);
        rst_n1 = 1'b0;
        tick();
        rst_n1 = 1'b1;
        check("ra_busy", busy, 0);
        check("ra_alu_oe", alu_oe, 0);
        check("ra_done_cnt", done_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            check("ra_no_rsp", {rsp0_valid, rsp1_valid}, 0);
            tick();
        end

        // ---- done_cnt wraps from 16'hFFFF to 0
        force u1.done_cnt_q = 16'hFFFF;
        #1;
        release u1.done_cnt_q;
        #1;
        check("wrap_preload", done_cnt, 16'hFFFF);
        run_vec("wrap_op", 1'b0, 2'b00, 8'h05, 8'h03, 8'h08, 5'b10100);
        check("wrap_done_cnt", done_cnt, 16'h0000);

        // ---- ALU_LAT=3 instance
        rst_n1 = 1'b0;
        rst_n3 = 1'b1;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 8'h10; req1_b = 8'h20;
        #1;
        check("l3_req1_ready", req1_ready_3, 1);
        tick();
        req1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("l3_oe", alu_oe_3, 1);
            check("l3_alu_ops", {alu_op_3, alu_a_3, alu_b_3}, {2'b01, 8'h10, 8'h20});
            check("l3_no_rsp", rsp1_valid_3, 0);
            tick();
        end
        check("l3_oe_off", alu_oe_3, 0);
        check("l3_alu_ab_zero", {alu_a_3, alu_b_3}, 0);
        check("l3_rsp1_valid", rsp1_valid_3, 1);
        check("l3_rsp0_valid", rsp0_valid_3, 0);
        check("l3_rsp_y", rsp_y_3, 8'hF0);
        check("l3_less", rsp_flags_3[0], 1);
        check("l3_flags", rsp_flags_3, 5'b00001);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        check("l3_done_cnt", done_cnt_3, 1);
        check("l3_idle", busy_3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
